hazard_ctrl_sb: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage RV32 pipeline, replacing the fixed stall/flush/forward wiring between fetch, decode, execute, memory and writeback. It adds four capabilities: variable-latency data-memory stalls through a wait state machine, a bounded memory timeout with a sticky error flag, explicit stall/flush outputs for all five stage registers, and optional saturating performance counters. It sits beside the pipe_* stage registers and drives their stall/flush inputs and the execute-stage forward muxes.

---
 rtl/hazard_ctrl_sb.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl_sb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_sb.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: forward selects, load-use and branch
// handling, variable-latency data-memory wait with timeout. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_ctrl_sb #(
    parameter int REG_AW = 5,
    parameter int MEM_TO = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr_D,
    input  logic [REG_AW-1:0] rs2_addr_D,
    input  logic              use_rs1_D,
    input  logic              use_rs2_D,
    input  logic [REG_AW-1:0] rs1_addr_E,
    input  logic [REG_AW-1:0] rs2_addr_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              reg_wr_E,
    input  logic              mem_rd_E,
    input  logic              br_en_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic              reg_wr_M,
    input  logic              mem_rd_M,
    input  logic              dmem_ready_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_wr_W,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WCNT_W  = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;
    localparam int TO_LAST = (MEM_TO > 0) ? MEM_TO - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_nxt;
    logic              mem_err_nxt;
    logic              mem_stall;
    logic              load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_m,
        input logic              ld_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              wr_w
    );
        // A load in M has no result yet; it can only be forwarded once it reaches W.
        if (wr_m && !ld_m && (rd_m != '0) && (rd_m == src))
            fwd_sel = 2'b11;
        else if (wr_w && (rd_w != '0) && (rd_w == src))
            fwd_sel = 2'b01;
        else
            fwd_sel = 2'b00;
    endfunction

    assign load_use = mem_rd_E && reg_wr_E && (rd_E != '0) &&
                      ((use_rs1_D && (rd_E == rs1_addr_D)) ||
                       (use_rs2_D && (rd_E == rs2_addr_D)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    // mem_stall is Mealy so the first missing-data cycle already holds the pipeline.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        mem_stall    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd_M && !dmem_ready_M) begin
                    mem_stall    = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (!mem_rd_M || dmem_ready_M) begin
                    state_nxt = IDLE;
                end else begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                    if ((MEM_TO != 0) && (wait_cnt == WCNT_W'(TO_LAST))) begin
                        state_nxt   = ERR;
                        mem_err_nxt = 1'b1;
                    end
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A frozen E stage re-presents its branch/load after the memory stall, so both are masked here.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (br_en_E) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
            ForwardAE = fwd_sel(rs1_addr_E, rd_M, reg_wr_M, mem_rd_M, rd_W, reg_wr_W);
            ForwardBE = fwd_sel(rs2_addr_E, rd_M, reg_wr_M, mem_rd_M, rd_W, reg_wr_W);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        sat_inc = (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, stallF);
            flush_cnt_q <= sat_inc(flush_cnt_q, flushD | flushE);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Scoreboard bench for hazard_ctrl_sb: directed cases then randomized traffic against a cycle-level model.
module tb_hazard_ctrl_sb;
    localparam int REG_AW = 5;
    localparam int MEM_TO = 4;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [REG_AW-1:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W;
    logic              use_rs1_D, use_rs2_D, reg_wr_E, mem_rd_E, br_en_E;
    logic              reg_wr_M, mem_rd_M, dmem_ready_M, reg_wr_W;
    logic              stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    hazard_ctrl_sb #(.REG_AW(REG_AW), .MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E), .rd_E(rd_E),
        .reg_wr_E(reg_wr_E), .mem_rd_E(mem_rd_E), .br_en_E(br_en_E),
        .rd_M(rd_M), .reg_wr_M(reg_wr_M), .mem_rd_M(mem_rd_M), .dmem_ready_M(dmem_ready_M),
        .rd_W(rd_W), .reg_wr_W(reg_wr_W),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic sF, sD, sE, sM, fD, fE, fW;
        logic [1:0] fa, fb;
        logic err;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: length of the current memory stall, timeout bookkeeping, counters.
    int m_run = 0;
    bit m_err_cyc = 0;
    bit m_err = 0;
    int m_sc = 0;
    int m_fc = 0;

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
        // Newest producer wins: an ALU result in M, else whatever W writes back, else the register file.
        if (src == '0) return 2'b00;
        if (reg_wr_M && !mem_rd_M && rd_M == src) return 2'b11;
        if (reg_wr_W && rd_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        bit mstall;
        bit hazard;
        e = '0;
        if (rst) begin
            mstall = mem_rd_M && !dmem_ready_M && !m_err_cyc;
            hazard = mem_rd_E && reg_wr_E && rd_E != '0 &&
                     ((use_rs1_D && rd_E == rs1_addr_D) || (use_rs2_D && rd_E == rs2_addr_D));
            if (mstall) begin
                e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1; e.fW = 1;
            end else if (br_en_E) begin
                e.fD = 1; e.fE = 1;
            end else if (hazard) begin
                e.sF = 1; e.sD = 1; e.fE = 1;
            end
            e.fa = ref_fwd(rs1_addr_E);
            e.fb = ref_fwd(rs2_addr_E);
            e.err = m_err;
`ifdef HAZ_PERF_CNT_EN
            e.sc = CNT_W'(m_sc);
            e.fc = CNT_W'(m_fc);
`endif
        end
        return e;
    endfunction

    task automatic model_advance(input exp_t e);
        if (!rst) begin
            m_run = 0; m_err_cyc = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e.sM) m_run++;
            else m_run = 0;
            // After MEM_TO+1 stalled cycles the load is released with an error.
            m_err_cyc = (MEM_TO != 0) && (m_run == MEM_TO + 1);
            if (m_err_cyc) begin
                m_err = 1;
                m_run = 0;
            end
            if (e.sF && m_sc < CNT_MAX) m_sc++;
            if ((e.fD || e.fE) && m_fc < CNT_MAX) m_fc++;
        end
    endtask

    task automatic cycle();
        exp_t e;
        e = model_outputs();
        exp_q.push_back(e);
        @(posedge clk);
        model_advance(e);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic quiet();
        rs1_addr_D = '0; rs2_addr_D = '0; use_rs1_D = 0; use_rs2_D = 0;
        rs1_addr_E = '0; rs2_addr_E = '0; rd_E = '0;
        reg_wr_E = 0; mem_rd_E = 0; br_en_E = 0;
        rd_M = '0; reg_wr_M = 0; mem_rd_M = 0; dmem_ready_M = 0;
        rd_W = '0; reg_wr_W = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output vector, compared against the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stallF", 32'(stallF), 32'(e.sF));
                chk("stallD", 32'(stallD), 32'(e.sD));
                chk("stallE", 32'(stallE), 32'(e.sE));
                chk("stallM", 32'(stallM), 32'(e.sM));
                chk("flushD", 32'(flushD), 32'(e.fD));
                chk("flushE", 32'(flushE), 32'(e.fE));
                chk("flushW", 32'(flushW), 32'(e.fW));
                chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
                chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
                chk("mem_err", 32'(mem_err), 32'(e.err));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
                chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld_lat;
        quiet();
        rst = 0;
        @(posedge clk); #1;
        cycles(2);
        rst = 1;
        cycle();

        // Forwarding: M priority, W fallback, x0 never forwarded, loads in M not forwarded.
        rd_M = 5; reg_wr_M = 1; rs1_addr_E = 5; cycle();
        rd_W = 5; reg_wr_W = 1; cycle();
        rd_M = 0; rd_W = 0; rs1_addr_E = 0; cycle();
        rd_W = 9; reg_wr_W = 1; rs2_addr_E = 9; cycle();
        rd_M = 9; mem_rd_M = 1; dmem_ready_M = 1; rs1_addr_E = 9; cycle();
        quiet();

        // Load-use, then the bubble that follows it.
        mem_rd_E = 1; reg_wr_E = 1; rd_E = 7; rs2_addr_D = 7; use_rs2_D = 1; cycle();
        quiet(); cycle();
        // Load-use squashed by a branch.
        mem_rd_E = 1; reg_wr_E = 1; rd_E = 7; rs2_addr_D = 7; use_rs2_D = 1; br_en_E = 1; cycle();
        quiet(); cycle();

        // Three-cycle memory wait overlapping a load-use hazard.
        mem_rd_M = 1; dmem_ready_M = 0;
        mem_rd_E = 1; reg_wr_E = 1; rd_E = 3; rs1_addr_D = 3; use_rs1_D = 1;
        cycles(3);
        dmem_ready_M = 1; cycle();
        quiet(); cycles(2);

        // Timeout: 5 stalled cycles, one release cycle, sticky error.
        mem_rd_M = 1; dmem_ready_M = 0; br_en_E = 1; cycles(6);
        quiet(); cycles(3);

        // Reset in the middle of a wait.
        mem_rd_M = 1; dmem_ready_M = 0; cycles(2);
        rst = 0; cycle();
        rst = 1; quiet(); cycles(2);

        // Twenty load-use stall cycles drive the stall counter into saturation.
        mem_rd_E = 1; reg_wr_E = 1; rd_E = 4; rs1_addr_D = 4; use_rs1_D = 1; cycles(20);
        quiet(); cycle();

        // Randomized traffic with occasional variable-latency loads and reset pulses.
        ld_lat = -1;
        for (int n = 0; n < 2000; n++) begin
            rs1_addr_D = REG_AW'($urandom_range(0, 7));
            rs2_addr_D = REG_AW'($urandom_range(0, 7));
            use_rs1_D = 1'($urandom_range(0, 1));
            use_rs2_D = 1'($urandom_range(0, 1));
            rs1_addr_E = REG_AW'($urandom_range(0, 7));
            rs2_addr_E = REG_AW'($urandom_range(0, 7));
            rd_E = REG_AW'($urandom_range(0, 7));
            reg_wr_E = 1'($urandom_range(0, 1));
            mem_rd_E = 1'($urandom_range(0, 1));
            br_en_E = ($urandom_range(0, 7) == 0);
            rd_M = REG_AW'($urandom_range(0, 7));
            reg_wr_M = 1'($urandom_range(0, 1));
            rd_W = REG_AW'($urandom_range(0, 7));
            reg_wr_W = 1'($urandom_range(0, 1));
            if (ld_lat < 0 && $urandom_range(0, 3) == 0)
                ld_lat = ($urandom_range(0, 7) == 0) ? 8 : int'($urandom_range(0, 3));
            if (ld_lat >= 0) begin
                mem_rd_M = 1;
                dmem_ready_M = (ld_lat == 0);
                ld_lat--;
            end else begin
                mem_rd_M = 0;
                dmem_ready_M = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst = 1; quiet(); cycles(2);

        @(negedge clk); @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
